// File: rtl/wide_exec_seq_if.sv
// Bus between the 16-bit execute sequencer, its controller and the 8-bit ALU.
// The slave side is the sequencer; the master side is the controller plus ALU.
interface wide_exec_seq_if;
    logic        start;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        sc_in;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_op;
    logic        alu_sc_in;
    logic [7:0]  alu_out;
    logic        alu_sc_out;
    logic        alu_zero;
    logic [15:0] result;
    logic        carry;
    logic        zero16;
    logic        busy;
    logic        done;

    modport slave (
        input  start, op, a, b, sc_in, alu_out, alu_sc_out, alu_zero,
        output alu_a, alu_b, alu_op, alu_sc_in, result, carry, zero16, busy, done
    );

    modport master (
        output start, op, a, b, sc_in, alu_out, alu_sc_out, alu_zero,
        input  alu_a, alu_b, alu_op, alu_sc_in, result, carry, zero16, busy, done
    );
endinterface

// File: rtl/wide_exec_seq.sv
// Two-pass 16-bit execute sequencer: drives an 8-bit ALU once per byte, chaining
// the carry/shift bit between passes, and returns a registered 16-bit result.
module wide_exec_seq (
    input  logic            clk_i,
    input  logic            rst_ni,
    wide_exec_seq_if.slave  bus
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_LSH = 3'b001;
    localparam logic [2:0] OP_RSH = 3'b010;
    localparam logic [2:0] OP_NOP = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_FIRST, S_SECOND} state_t;

    state_t      state_q, state_d;
    logic [15:0] op_a_q, op_b_q;
    logic [2:0]  op_r_q;
    logic        c_q, msw_first_q, z1_q;
    logic [15:0] res_q;
    logic [15:0] result_q;
    logic        carry_q, zero16_q, done_q;
    logic        chained;
    logic        hi_sel;

    assign chained = (op_r_q == OP_ADD) || (op_r_q == OP_LSH) || (op_r_q == OP_RSH);
    // Byte under work: FIRST takes the MSB only for right shifts, SECOND takes the other one.
    assign hi_sel  = (state_q == S_FIRST) ? msw_first_q : ~msw_first_q;

    always_comb begin
        state_d       = state_q;
        bus.alu_a     = 8'h00;
        bus.alu_b     = 8'h00;
        bus.alu_op    = OP_NOP;
        bus.alu_sc_in = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_FIRST;
            end
            S_FIRST, S_SECOND: begin
                bus.alu_a     = hi_sel ? op_a_q[15:8] : op_a_q[7:0];
                bus.alu_b     = hi_sel ? op_b_q[15:8] : op_b_q[7:0];
                bus.alu_op    = op_r_q;
                bus.alu_sc_in = chained & c_q;
                state_d       = (state_q == S_FIRST) ? S_SECOND : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_a_q      <= 16'h0000;
            op_b_q      <= 16'h0000;
            op_r_q      <= 3'b000;
            c_q         <= 1'b0;
            msw_first_q <= 1'b0;
            z1_q        <= 1'b0;
            res_q       <= 16'h0000;
            result_q    <= 16'h0000;
            carry_q     <= 1'b0;
            zero16_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        op_a_q      <= bus.a;
                        op_b_q      <= bus.b;
                        op_r_q      <= bus.op;
                        c_q         <= bus.sc_in;
                        msw_first_q <= (bus.op == OP_RSH);
                    end
                end
                S_FIRST: begin
                    if (hi_sel) res_q[15:8] <= bus.alu_out;
                    else        res_q[7:0]  <= bus.alu_out;
                    c_q  <= bus.alu_sc_out;
                    z1_q <= bus.alu_zero;
                end
                S_SECOND: begin
                    // The second byte is merged straight into the visible result.
                    result_q <= hi_sel ? {bus.alu_out, res_q[7:0]} : {res_q[15:8], bus.alu_out};
                    carry_q  <= bus.alu_sc_out;
                    zero16_q <= z1_q & bus.alu_zero;
                    done_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.carry  = carry_q;
    assign bus.zero16 = zero16_q;
    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = done_q;
endmodule

// File: tb/tb_wide_exec_seq.sv
// Bench for wide_exec_seq: behavioural 8-bit ALU on the bus, 16-bit reference
// model computed directly with whole-word arithmetic.
module tb_wide_exec_seq;
    logic clk;
    logic rst_n;
    int   vec_cnt;
    int   miscompares;

    wide_exec_seq_if bus ();

    wide_exec_seq dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit ALU: 0 ADD, 1 LSH, 2 RSH, 3 XOR, 4 AND, 5 OR, 6 SUB, 7 no-op.
    always_comb begin
        logic [8:0] s;
        s = 9'h000;
        bus.alu_out    = 8'h00;
        bus.alu_sc_out = 1'b0;
        case (bus.alu_op)
            3'd0: begin
                s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'h00, bus.alu_sc_in};
                bus.alu_out    = s[7:0];
                bus.alu_sc_out = s[8];
            end
            3'd1: begin bus.alu_out = {bus.alu_a[6:0], bus.alu_sc_in}; bus.alu_sc_out = bus.alu_a[7]; end
            3'd2: begin bus.alu_out = {bus.alu_sc_in, bus.alu_a[7:1]}; bus.alu_sc_out = bus.alu_a[0]; end
            3'd3: bus.alu_out = bus.alu_a ^ bus.alu_b;
            3'd4: bus.alu_out = bus.alu_a & bus.alu_b;
            3'd5: bus.alu_out = bus.alu_a | bus.alu_b;
            3'd6: bus.alu_out = bus.alu_a - bus.alu_b;
            default: bus.alu_out = 8'h00;
        endcase
        bus.alu_zero = (bus.alu_out == 8'h00);
    end

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns {carry, result} of the full 16-bit operation.
    function automatic logic [16:0] ref_op(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic sc);
        logic [16:0] r;
        case (op)
            3'd0: r = {1'b0, a} + {1'b0, b} + {16'h0000, sc};
            3'd1: r = {a[15], a[14:0], sc};
            3'd2: r = {a[0], sc, a[15:1]};
            3'd3: r = {1'b0, a ^ b};
            3'd4: r = {1'b0, a & b};
            3'd5: r = {1'b0, a | b};
            3'd6: r = {1'b0, a[15:8] - b[15:8], a[7:0] - b[7:0]};
            default: r = 17'h00000;
        endcase
        return r;
    endfunction

    // Carry passed from the first byte to the second for chained ops.
    function automatic logic mid_carry(input logic [2:0] op, input logic [15:0] a,
                                       input logic [15:0] b, input logic sc);
        logic [8:0] s;
        s = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'h00, sc};
        case (op)
            3'd0:    return s[8];
            3'd1:    return a[7];
            3'd2:    return a[8];
            default: return 1'b0;
        endcase
    endfunction

    // Caller enters mid-cycle; returns 1 ns after the edge that raises DONE.
    task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic sc, input bit hold_start);
        logic [16:0] exp;
        logic        chained;
        logic        msw;
        exp     = ref_op(op, a, b, sc);
        chained = (op <= 3'd2);
        msw     = (op == 3'd2);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.sc_in = sc;
        @(posedge clk); #1;
        check_vec("first_busy", bus.busy, 1'b1);
        check_vec("first_alu_a", bus.alu_a, msw ? a[15:8] : a[7:0]);
        check_vec("first_alu_b", bus.alu_b, msw ? b[15:8] : b[7:0]);
        check_vec("first_alu_op", bus.alu_op, op);
        check_vec("first_sc_in", bus.alu_sc_in, chained ? sc : 1'b0);
        bus.start = hold_start;
        bus.op    = 3'($urandom_range(0, 7));
        bus.a     = 16'($urandom);
        bus.b     = 16'($urandom);
        bus.sc_in = 1'($urandom);
        @(posedge clk); #1;
        check_vec("second_busy", bus.busy, 1'b1);
        check_vec("second_alu_a", bus.alu_a, msw ? a[7:0] : a[15:8]);
        check_vec("second_sc_in", bus.alu_sc_in, mid_carry(op, a, b, sc));
        check_vec("second_done", bus.done, 1'b0);
        bus.start = 1'b0;
        @(posedge clk); #1;
        check_vec("done", bus.done, 1'b1);
        check_vec("done_busy", bus.busy, 1'b0);
        check_vec("result", bus.result, exp[15:0]);
        check_vec("carry", bus.carry, exp[16]);
        check_vec("zero16", bus.zero16, exp[15:0] == 16'h0000);
    endtask

    task automatic idle_cycle(input logic [16:0] exp);
        @(posedge clk); #1;
        check_vec("idle_done", bus.done, 1'b0);
        check_vec("idle_busy", bus.busy, 1'b0);
        check_vec("idle_alu_op", bus.alu_op, 3'b111);
        check_vec("idle_alu_a", bus.alu_a, 8'h00);
        check_vec("idle_hold", bus.result, exp[15:0]);
    endtask

    initial begin
        logic [2:0]  op;
        logic [15:0] a, b;
        logic        sc;
        vec_cnt     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.op      = 3'd0;
        bus.a       = 16'h0000;
        bus.b       = 16'h0000;
        bus.sc_in   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_vec("rst_result", bus.result, 16'h0000);
        check_vec("rst_carry", bus.carry, 1'b0);
        check_vec("rst_zero16", bus.zero16, 1'b0);
        check_vec("rst_busy", bus.busy, 1'b0);
        check_vec("rst_done", bus.done, 1'b0);
        check_vec("rst_alu_op", bus.alu_op, 3'b111);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(3'd0, 16'h00FF, 16'h0001, 1'b0, 1'b0);
        idle_cycle(ref_op(3'd0, 16'h00FF, 16'h0001, 1'b0));
        run_op(3'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        idle_cycle(ref_op(3'd0, 16'hFFFF, 16'h0001, 1'b0));
        run_op(3'd1, 16'h80C1, 16'h0000, 1'b1, 1'b0);
        idle_cycle(ref_op(3'd1, 16'h80C1, 16'h0000, 1'b1));
        run_op(3'd2, 16'h0103, 16'h0000, 1'b0, 1'b0);
        idle_cycle(ref_op(3'd2, 16'h0103, 16'h0000, 1'b0));
        // START held through FIRST is ignored; a new START in the DONE cycle is accepted.
        run_op(3'd3, 16'h0F0F, 16'h0FF0, 1'b1, 1'b1);
        run_op(3'd0, 16'h1234, 16'h4321, 1'b1, 1'b0);
        idle_cycle(ref_op(3'd0, 16'h1234, 16'h4321, 1'b1));

        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = 16'($urandom);
            b  = 16'($urandom);
            sc = 1'($urandom);
            if ((i % 7) == 3) a = 16'h0000;
            if ((i % 5) == 1) b = 16'hFFFF;
            run_op(op, a, b, sc, 1'($urandom));
            if ($urandom_range(0, 1) == 1) idle_cycle(ref_op(op, a, b, sc));
        end

        // Reset during SECOND abandons the operation.
        bus.start = 1'b1;
        bus.op    = 3'd0;
        bus.a     = 16'h00FF;
        bus.b     = 16'h0001;
        bus.sc_in = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        check_vec("pre_rst_busy", bus.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_vec("mid_rst_busy", bus.busy, 1'b0);
        check_vec("mid_rst_done", bus.done, 1'b0);
        check_vec("mid_rst_result", bus.result, 16'h0000);
        check_vec("mid_rst_alu_op", bus.alu_op, 3'b111);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) idle_cycle(17'h00000);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end
endmodule
